// File: rtl/computer_system_gpi_pkg.sv
// rtl/computer_system_gpi_pkg.sv - shared constants for the general-purpose input block
//
// Purpose: register word addresses and edge-select encodings used by the
// computer_system_gpi top and its bench.
// Ports: none (package).

package computer_system_gpi_pkg;

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_MASK     = 3'd2;
  localparam logic [2:0] ADDR_EDGE     = 3'd3;
  localparam logic [2:0] ADDR_MASK_SET = 3'd4;
  localparam logic [2:0] ADDR_MASK_CLR = 3'd5;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/computer_system_gpi_if.sv
// rtl/computer_system_gpi_if.sv - Avalon-MM slave bus bundle for the input block
//
// Purpose: groups the register-bus signals and the interrupt line.
// Signals:
//   address[2:0]    word address          (master -> slave)
//   chipselect      slave select          (master -> slave)
//   write_n         active-low write      (master -> slave)
//   writedata[31:0] write data            (master -> slave)
//   readdata[31:0]  registered read data  (slave -> master)
//   irq             interrupt request     (slave -> master)

interface computer_system_gpi_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/gpi_debounce.sv
// rtl/gpi_debounce.sv - single-bit debounce filter
//
// Purpose: q follows d only after d has disagreed with q for DEBOUNCE_CYCLES
// consecutive cycles; any agreement restarts the count.
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   d        synchronized input bit
//   q        filtered output bit

module gpi_debounce import computer_system_gpi_pkg::*; #(
  parameter int DEBOUNCE_CYCLES = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q   <= 1'b0;
      cnt <= '0;
    end else if (d == q) begin
      cnt <= '0;
    end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
      // this is the DEBOUNCE_CYCLES-th consecutive disagreeing cycle
      q   <= d;
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/computer_system_gpi.sv
// rtl/computer_system_gpi.sv - debounced input port with sticky edge capture and irq
//
// Purpose: synchronizes and debounces in_port, exposes the filtered value,
// latches selected edges into a write-1-to-clear capture register and raises
// irq while any captured bit is enabled in irqmask.
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   in_port  asynchronous external inputs, WIDTH bits
//   bus      register bus slave (address/chipselect/write_n/writedata/readdata/irq)

module computer_system_gpi import computer_system_gpi_pkg::*; #(
  parameter int WIDTH           = 12,
  parameter int EDGE_TYPE       = 0,
  parameter int DEBOUNCE_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WIDTH-1:0]     in_port,
  computer_system_gpi_if.slave bus
);

  logic [WIDTH-1:0] s1, s2, f, prev;
  logic [WIDTH-1:0] capture, irqmask;
  logic [WIDTH-1:0] rise, fall, edges, clr, wdata;
  logic [31:0]      rd_mux;
  logic             wr;
  logic             unused_wdata;

  assign wr           = bus.chipselect & ~bus.write_n;
  assign wdata        = bus.writedata[WIDTH-1:0];
  assign unused_wdata = &{1'b0, bus.writedata};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1   <= '0;
      s2   <= '0;
      prev <= '0;
    end else begin
      s1   <= in_port;
      s2   <= s1;
      prev <= f;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_deb
    gpi_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (s2[i]),
      .q       (f[i])
    );
  end

  always_comb begin
    rise = f & ~prev;
    fall = ~f & prev;
    case (EDGE_TYPE)
      EDGE_FALL: edges = fall;
      EDGE_ANY:  edges = rise | fall;
      default:   edges = rise;
    endcase
    clr = (wr && bus.address == ADDR_EDGE) ? wdata : '0;
  end

  always_comb begin
    rd_mux = '0;
    case (bus.address)
      ADDR_DATA: rd_mux[WIDTH-1:0] = f;
      ADDR_MASK: rd_mux[WIDTH-1:0] = irqmask;
      ADDR_EDGE: rd_mux[WIDTH-1:0] = capture;
      default:   rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      capture      <= '0;
      irqmask      <= '0;
      bus.readdata <= '0;
    end else begin
      // OR-ing edges after the clear lets a fresh edge beat a same-cycle clear
      capture      <= (capture & ~clr) | edges;
      bus.readdata <= rd_mux;
      if (wr) begin
        case (bus.address)
          ADDR_MASK:     irqmask <= wdata;
          ADDR_MASK_SET: irqmask <= irqmask | wdata;
          ADDR_MASK_CLR: irqmask <= irqmask & ~wdata;
          default:       irqmask <= irqmask;
        endcase
      end
    end
  end

  assign bus.irq = |(capture & irqmask);

endmodule
